// File: rtl/du_pkg.sv
// rtl/du_pkg.sv - shared debug-unit constants: serializer state encoding, UART byte width, byte-count helper
package du_pkg;

    localparam int NB_BYTE_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_CKSUM = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Also sizes the debug unit's RX/TX loops, so keep it a plain function.
    function automatic int du_n_bytes(input int nb_data, input int nb_byte);
        return (nb_data + nb_byte - 1) / nb_byte;
    endfunction

endpackage

// File: rtl/du_latch_serializer.sv
// rtl/du_latch_serializer.sv - captures the pipeline latch vector and streams it LSB byte first to the UART TX FIFO
// Optional trailing XOR checksum byte when DU_SER_CHECKSUM_EN is defined.
module du_latch_serializer
    import du_pkg::*;
#(
    parameter int NB_DATA = 341,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_byte_ready,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_byte_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int N_BYTES  = du_n_bytes(NB_DATA, NB_BYTE);
    localparam int NB_SHIFT = N_BYTES * NB_BYTE;
    localparam int NB_CNT   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_BYTES - 1);

    logic [1:0]          state_q, state_d;
    logic [NB_SHIFT-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
`ifdef DU_SER_CHECKSUM_EN
    logic [NB_BYTE-1:0]  xor_q, xor_d;
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
`ifdef DU_SER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        o_byte_valid = 1'b0;
        o_byte       = '0;
        o_busy       = (state_q != ST_IDLE);
        o_done       = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SEND;
                    shift_d = NB_SHIFT'(i_data);
                    cnt_d   = '0;
`ifdef DU_SER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_SEND: begin
                o_byte_valid = 1'b1;
                o_byte       = shift_q[NB_BYTE-1:0];
                if (i_byte_ready) begin
                    shift_d = shift_q >> NB_BYTE;
`ifdef DU_SER_CHECKSUM_EN
                    xor_d   = xor_q ^ shift_q[NB_BYTE-1:0];
`endif
                    // Terminal compare ends SEND, so the counter never wraps.
                    if (cnt_q == CNT_LAST) begin
`ifdef DU_SER_CHECKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef DU_SER_CHECKSUM_EN
            ST_CKSUM: begin
                o_byte_valid = 1'b1;
                o_byte       = xor_q;
                if (i_byte_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef DU_SER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef DU_SER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_du_latch_serializer.sv
// tb/tb_du_latch_serializer.sv - randomized and directed self-check of du_latch_serializer against a byte-queue model
module tb_du_latch_serializer;

    localparam int NB  = 341;
    localparam int NBY = 43;
`ifdef DU_SER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [NB-1:0] i_data = '0;
    logic          i_byte_ready = 1'b1;
    logic [7:0]    o_byte;
    logic          o_byte_valid, o_busy, o_done;

    logic          start8 = 1'b0;
    logic [7:0]    data8 = '0;
    logic [7:0]    byte8;
    logic          valid8, busy8, done8;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] cap [0:63];
    logic [7:0] exp_q [$];
    bit m_active = 0;
    bit m_done   = 0;

    always #10 clk = ~clk;

    du_latch_serializer #(.NB_DATA(NB), .NB_BYTE(8)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_data(i_data),
        .i_byte_ready(i_byte_ready), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    du_latch_serializer #(.NB_DATA(8), .NB_BYTE(8)) dut8 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start8), .i_data(data8),
        .i_byte_ready(1'b1), .o_byte(byte8), .o_byte_valid(valid8),
        .o_busy(busy8), .o_done(done8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void load_frame(input logic [NB-1:0] d);
        logic [NBY*8-1:0] ext;
        logic [7:0] x;
        ext = {3'b000, d};
        x = 8'h00;
        exp_q.delete();
        for (int i = 0; i < NBY; i++) begin
            exp_q.push_back(ext[8*i +: 8]);
            x ^= ext[8*i +: 8];
        end
`ifdef DU_SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    function automatic logic [NB-1:0] rnd_data();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[32*i +: 32] = $urandom;
        return t[NB-1:0];
    endfunction

    // Frame-level model: a pending byte queue plus a done marker one cycle after the last transfer.
    always @(negedge clk) begin
        bit was_idle;
        if (!rst_n) begin
            check("rst_valid", {31'b0, o_byte_valid}, 32'd0);
            check("rst_done",  {31'b0, o_done}, 32'd0);
            check("rst_busy",  {31'b0, o_busy}, 32'd0);
            check("rst_byte",  {24'b0, o_byte}, 32'd0);
            m_active = 0;
            m_done   = 0;
            exp_q.delete();
        end else begin
            check("valid", {31'b0, o_byte_valid}, {31'b0, m_active});
            check("done",  {31'b0, o_done}, {31'b0, m_done});
            check("busy",  {31'b0, o_busy}, {31'b0, (m_active || m_done)});
            if (m_active && exp_q.size() > 0)
                check("byte", {24'b0, o_byte}, {24'b0, exp_q[0]});
            was_idle = !m_active && !m_done;
            m_done = 0;
            if (m_active && i_byte_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
            if (was_idle && i_start) begin
                load_frame(i_data);
                m_active = 1;
            end
        end
    end

    task automatic pulse_start(input logic [NB-1:0] d);
        @(posedge clk); #1;
        i_data  = d;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic capture_frame(input logic [NB-1:0] d, output int done_n);
        pulse_start(d);
        done_n = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (o_byte_valid) cap[n] = o_byte;
            if (o_done) begin
                done_n = n;
                break;
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = o_done;
        end
        check(name, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        logic [383:0] p;
        logic [NB-1:0] pat;
        int dn;
        p   = {6{64'h0123456789ABCDEF}};
        pat = p[NB-1:0];

        #35;
        check("reset_valid", {31'b0, o_byte_valid}, 32'd0);
        check("reset_busy",  {31'b0, o_busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pattern frame, ready held high
        i_byte_ready = 1'b1;
        capture_frame(pat, dn);
        check("t1_byte0",  {24'b0, cap[1]}, 32'hEF);
        check("t1_byte42", {24'b0, cap[43]}, 32'h0B);
        check("t1_done_cycle", dn, 44 + CK);

        // Stall on byte 10 for five cycles
        pulse_start(pat);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 10) i_byte_ready = 1'b0;
            if (c == 15) i_byte_ready = 1'b1;
            if (c >= 10 && c < 15) begin
                @(negedge clk);
                check("t2_hold", {23'b0, o_byte_valid, o_byte}, {23'b0, 1'b1, 8'hAB});
            end
        end
        wait_done("t2_done_seen");

        // Start mid-stream is ignored
        pulse_start(pat);
        repeat (2) @(posedge clk);
        #1;
        i_data  = ~pat;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done("t3_done_seen");
        repeat (4) @(posedge clk);

        // Async reset mid-stream
        pulse_start(pat);
        repeat (19) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("t4_valid", {31'b0, o_byte_valid}, 32'd0);
        check("t4_busy",  {31'b0, o_busy}, 32'd0);
        check("t4_byte",  {24'b0, o_byte}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        capture_frame(pat, dn);
        check("t4_full_frame", dn, 44 + CK);

        // All-ones frame
        capture_frame({NB{1'b1}}, dn);
        check("t5_byte41", {24'b0, cap[42]}, 32'hFF);
        check("t5_byte42", {24'b0, cap[43]}, 32'h1F);
`ifdef DU_SER_CHECKSUM_EN
        check("t5_cksum", {24'b0, cap[44]}, 32'h1F);
`endif
        check("t5_done_cycle", dn, 44 + CK);

        // Single-byte instance
        @(posedge clk); #1;
        data8  = 8'hA5;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        check("t6_byte", {23'b0, valid8, byte8}, {23'b0, 1'b1, 8'hA5});
        check("t6_busy", {31'b0, busy8}, 32'd1);
`ifdef DU_SER_CHECKSUM_EN
        @(negedge clk);
        check("t6_cksum", {23'b0, valid8, byte8}, {23'b0, 1'b1, 8'hA5});
`endif
        @(negedge clk);
        check("t6_done", {30'b0, done8, valid8}, 32'd2);

        // Randomized frames with random backpressure and stray starts
        for (int f = 0; f < 25; f++) begin
            bit seen;
            pulse_start(rnd_data());
            seen = 0;
            for (int c = 0; c < 400 && !seen; c++) begin
                i_byte_ready = ($urandom_range(0, 3) != 0);
                i_start      = ($urandom_range(0, 15) == 0);
                i_data       = rnd_data();
                @(negedge clk);
                seen = o_done;
                @(posedge clk); #1;
            end
            i_start = 1'b0;
            check("rand_done_seen", {31'b0, seen}, 32'd1);
        end
        i_byte_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
